// File: rtl/alu_sequencer.sv
// alu_sequencer: command sequencer and 8x16 operand store for an external
// four-function logic ALU. It accepts one command at a time, drives the
// registered operands and opcode to the ALU, writes the result back and
// returns it over a valid/ready response channel.
module alu_sequencer #(
    parameter int unsigned NREGS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [15:0] ld_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_rs1,
    input  logic [2:0]  cmd_rs2,
    input  logic [2:0]  cmd_rd,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_o,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [7:0]  done_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic [15:0] regs_q [NREGS];
    logic [15:0] regs_d [NREGS];
    logic [1:0]  alu_op_q,    alu_op_d;
    logic [15:0] alu_a_q,     alu_a_d;
    logic [15:0] alu_b_q,     alu_b_d;
    logic [2:0]  rd_q,        rd_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q,  rsp_data_d;
    logic [7:0]  done_cnt_q,  done_cnt_d;

    // Next-state logic: external load first, then the writeback, so the
    // writeback overrides a load aimed at the same register in EXEC.
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rd_d        = rd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        done_cnt_d  = done_cnt_q;

        if (ld_en) begin
            regs_d[ld_addr] = ld_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // operands come from regs_q, i.e. before any same-edge load
                    alu_op_d = cmd_op;
                    alu_a_d  = regs_q[cmd_rs1];
                    alu_b_d  = regs_q[cmd_rs2];
                    rd_d     = cmd_rd;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                regs_d[rd_q] = alu_o;
                rsp_data_d   = alu_o;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 8'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            regs_q      <= '{default: '0};
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    // Output drive and combinational debug read port.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        alu_op    = alu_op_q;
        alu_a     = alu_a_q;
        alu_b     = alu_b_q;
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        done_cnt  = done_cnt_q;
        rd_data   = regs_q[rd_addr];
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a
// behavioural model of the external logic ALU.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic [2:0]  cmd_rd;
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_o;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  done_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External ALU: 00 AND, 01 OR, 10 NAND, 11 NOR.
    always_comb begin
        case (alu_op)
            2'b00:   alu_o = alu_a & alu_b;
            2'b01:   alu_o = alu_a | alu_b;
            2'b10:   alu_o = ~(alu_a & alu_b);
            default: alu_o = ~(alu_a | alu_b);
        endcase
    end

    alu_sequencer #(.NREGS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_rd    (cmd_rd),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_o     (alu_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .done_cnt  (done_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic reg_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        rd_addr = a;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    // Full command with zero-stall response; quiet skips the per-step checks.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [2:0] rd, input logic [15:0] exp, input bit quiet);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_rd    = rd;
        if (!quiet) check("cmd_ready_before", 32'(cmd_ready), 32'd1);
        tick();                                  // accept edge N
        cmd_valid = 1'b0;
        if (!quiet) check("rsp_valid_N", 32'(rsp_valid), 32'd0);
        tick();                                  // edge N+1
        if (!quiet) begin
            check("rsp_valid_N1", 32'(rsp_valid), 32'd1);
            check("rsp_data", 32'(rsp_data), 32'(exp));
        end
        rsp_ready = 1'b1;
        tick();                                  // handshake edge N+2
        rsp_ready = 1'b0;
        if (!quiet) begin
            check("cmd_ready_after", 32'(cmd_ready), 32'd1);
            check("rsp_valid_after", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        cmd_rd    = '0;
        rsp_ready = 1'b0;
        rd_addr   = '0;
        #23;
        reset = 1'b1;
        #1;

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'h0);
        check("rst_done_cnt",  32'(done_cnt),  32'h0);
        check("rst_alu_a",     32'(alu_a),     32'h0);
        check("rst_alu_op",    32'(alu_op),    32'h0);
        reg_chk("rst_r5", 3'd5, 16'h0000);
        tick();

        // All four ops
        load(3'd1, 16'h00FF);
        load(3'd2, 16'h0F0F);
        run_cmd(2'b00, 3'd1, 3'd2, 3'd3, 16'h000F, 1'b0);
        check("alu_a_held", 32'(alu_a), 32'h00FF);
        check("alu_b_held", 32'(alu_b), 32'h0F0F);
        run_cmd(2'b01, 3'd1, 3'd2, 3'd4, 16'h0FFF, 1'b0);
        run_cmd(2'b10, 3'd1, 3'd2, 3'd5, 16'hFFF0, 1'b0);
        run_cmd(2'b11, 3'd1, 3'd2, 3'd6, 16'hF000, 1'b0);
        check("alu_op_held", 32'(alu_op), 32'h3);
        reg_chk("r3_and",  3'd3, 16'h000F);
        reg_chk("r4_or",   3'd4, 16'h0FFF);
        reg_chk("r5_nand", 3'd5, 16'hFFF0);
        reg_chk("r6_nor",  3'd6, 16'hF000);
        check("done_4", 32'(done_cnt), 32'd4);

        // Self-overwrite
        load(3'd1, 16'hAAAA);
        load(3'd2, 16'hFFFF);
        run_cmd(2'b10, 3'd1, 3'd2, 3'd1, 16'h5555, 1'b0);
        reg_chk("r1_self", 3'd1, 16'h5555);
        run_cmd(2'b00, 3'd1, 3'd1, 3'd7, 16'h5555, 1'b0);
        reg_chk("r7_and11", 3'd7, 16'h5555);
        check("done_6", 32'(done_cnt), 32'd6);

        // Backpressure: OR r3|r4 = 0x0FFF into r0; stray command targets r2
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_rs1   = 3'd3;
        cmd_rs2   = 3'd4;
        cmd_rd    = 3'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data",  32'(rsp_data),  32'h0FFF);
            check("bp_ready", 32'(cmd_ready), 32'd0);
            cmd_valid = (i == 4);
            cmd_op    = 2'b11;
            cmd_rs1   = 3'd1;
            cmd_rs2   = 3'd1;
            cmd_rd    = 3'd2;
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_ready_back", 32'(cmd_ready), 32'd1);
        check("bp_done_7", 32'(done_cnt), 32'd7);
        reg_chk("bp_r0", 3'd0, 16'h0FFF);
        reg_chk("bp_r2_untouched", 3'd2, 16'hFFFF);

        // Write conflict: load rs1 at accept edge, load rd at EXEC edge
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_rs1   = 3'd3;
        cmd_rs2   = 3'd4;
        cmd_rd    = 3'd5;
        ld_en     = 1'b1;
        ld_addr   = 3'd3;
        ld_data   = 16'hFFFF;
        tick();                                  // accept, r3 <= FFFF
        cmd_valid = 1'b0;
        ld_addr   = 3'd5;
        ld_data   = 16'h1234;
        tick();                                  // EXEC edge, writeback wins
        ld_en     = 1'b0;
        check("wc_rsp_data", 32'(rsp_data), 32'h000F);
        reg_chk("wc_rd_wins", 3'd5, 16'h000F);
        reg_chk("wc_rs1_loaded", 3'd3, 16'hFFFF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("wc_done_8", 32'(done_cnt), 32'd8);

        // Reset mid-operation: OR r1|r2 = 0xFFFF into r6, abort in EXEC
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_rs1   = 3'd1;
        cmd_rs2   = 3'd2;
        cmd_rd    = 3'd6;
        tick();
        cmd_valid = 1'b0;
        check("mr_alu_a_pre", 32'(alu_a), 32'h5555);
        #2;
        reset = 1'b0;
        #1;
        check("mr_alu_a",     32'(alu_a),     32'h0);
        check("mr_alu_b",     32'(alu_b),     32'h0);
        check("mr_rsp_data",  32'(rsp_data),  32'h0);
        check("mr_done",      32'(done_cnt),  32'h0);
        check("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        reg_chk("mr_r6", 3'd6, 16'h0000);
        tick();
        #2;
        reset = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rsp_ready = 1'b0;
        reg_chk("mr_r6_after", 3'd6, 16'h0000);
        check("mr_done_after", 32'(done_cnt), 32'h0);

        // Counter wrap
        for (int i = 0; i < 256; i++) begin
            run_cmd(2'b00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1);
        end
        check("wrap_0", 32'(done_cnt), 32'h00);
        run_cmd(2'b01, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0);
        check("wrap_1", 32'(done_cnt), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
